// File: rtl/robot_map_engine.sv
// Grid-map robot engine: holds an occupancy map, a robot pose and registered
// proximity sensors. Commands run IDLE -> EXEC -> SENSE with done during SENSE.
module robot_map_engine #(
  parameter int unsigned ROWS      = 10,
  parameter int unsigned COLS      = 20,
  parameter int unsigned CELL_W    = 3,
  parameter int unsigned START_ROW = 0,
  parameter int unsigned START_COL = 0,
  parameter int unsigned START_ORI = 0,
  localparam int unsigned RW = $clog2(ROWS),
  localparam int unsigned CW = $clog2(COLS)
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [2:0]        cmd_i,
  output logic              done_o,
  output logic              blocked_o,
  output logic [RW-1:0]     robo_row_o,
  output logic [CW-1:0]     robo_col_o,
  output logic [1:0]        robo_orientacao_o,
  output logic              head_out_o,
  output logic              left_out_o,
  output logic              under_out_o,
  output logic              barrier_out_o,
  input  logic              map_we_i,
  input  logic [RW-1:0]     map_row_i,
  input  logic [CW-1:0]     map_col_i,
  input  logic [CELL_W-1:0] map_wdata_i,
  input  logic [RW-1:0]     map_rd_row_i,
  input  logic [CW-1:0]     map_rd_col_i,
  output logic [CELL_W-1:0] map_rdata_o,
  output logic [15:0]       move_count_o
);

  localparam logic [2:0] CmdForward = 3'd1;
  localparam logic [2:0] CmdLeft    = 3'd2;
  localparam logic [2:0] CmdRight   = 3'd3;
  localparam logic [2:0] CmdClear   = 3'd4;

  localparam logic [2:0] CellWall    = 3'b001;
  localparam logic [2:0] CellBarrier = 3'b010;
  localparam logic [2:0] CellGarbage = 3'b011;

  typedef enum logic [1:0] {StIdle, StExec, StSense} state_e;

  typedef struct packed {
    logic          inmap;
    logic [RW-1:0] r;
    logic [CW-1:0] c;
  } nb_t;

  state_e            state_q;
  logic [2:0]        cmd_q;
  logic [RW-1:0]     row_q;
  logic [CW-1:0]     col_q;
  logic [1:0]        ori_q;
  logic              done_q, blk_q;
  logic              head_q, left_q, under_q, bar_q;
  logic [15:0]       mc_q;
  logic [CELL_W-1:0] map_q [ROWS][COLS];

  // Neighbour of (r,c) in direction d; inmap low when it falls off the grid.
  function automatic nb_t nbr(logic [RW-1:0] r, logic [CW-1:0] c, logic [1:0] d);
    int rr, cc;
    nb_t n;
    rr = int'(r);
    cc = int'(c);
    case (d)
      2'd0:    rr = rr - 1;
      2'd1:    cc = cc + 1;
      2'd2:    rr = rr + 1;
      default: cc = cc - 1;
    endcase
    n.inmap = (rr >= 0) && (rr < int'(ROWS)) && (cc >= 0) && (cc < int'(COLS));
    n.r     = RW'(rr);
    n.c     = CW'(cc);
    return n;
  endfunction

  nb_t           ahd, pa, pl;
  logic [2:0]    ahd_cell, pa_cell, pl_cell, un_cell;
  logic [RW-1:0] row_n;
  logic [CW-1:0] col_n;
  logic [1:0]    ori_n;
  logic          blk_n, clr, fwd_ok;
  logic          head_n, left_n, under_n, bar_n;
  logic          wr_in, rd_in;

  // Command execution plus sensor values for the post-execution pose/map.
  always_comb begin
    ahd      = nbr(row_q, col_q, ori_q);
    ahd_cell = ahd.inmap ? map_q[ahd.r][ahd.c][2:0] : CellWall;
    row_n    = row_q;
    col_n    = col_q;
    ori_n    = ori_q;
    blk_n    = 1'b0;
    clr      = 1'b0;
    fwd_ok   = 1'b0;
    case (cmd_q)
      CmdForward: begin
        if (ahd_cell == CellWall || ahd_cell == CellBarrier) begin
          blk_n = 1'b1;
        end else begin
          row_n  = ahd.r;
          col_n  = ahd.c;
          fwd_ok = 1'b1;
        end
      end
      CmdLeft:  ori_n = ori_q - 2'd1;
      CmdRight: ori_n = ori_q + 2'd1;
      CmdClear: clr = (ahd_cell == CellBarrier);
      default:  ;
    endcase
    pa      = nbr(row_n, col_n, ori_n);
    pl      = nbr(row_n, col_n, ori_n - 2'd1);
    pa_cell = pa.inmap ? map_q[pa.r][pa.c][2:0] : CellWall;
    // A clear only ever touches the ahead cell, so patch it in here.
    if (clr) pa_cell = 3'b000;
    pl_cell = pl.inmap ? map_q[pl.r][pl.c][2:0] : CellWall;
    un_cell = map_q[row_n][col_n][2:0];
    head_n  = (pa_cell == CellWall);
    left_n  = (pl_cell == CellWall);
    under_n = (un_cell == CellGarbage);
    bar_n   = (pa_cell == CellBarrier);
  end

  // Port address range checks and handshake.
  always_comb begin
    wr_in       = (32'(map_row_i) < ROWS) && (32'(map_col_i) < COLS);
    rd_in       = (32'(map_rd_row_i) < ROWS) && (32'(map_rd_col_i) < COLS);
    cmd_ready_o = (state_q == StIdle) && !map_we_i;
    map_rdata_o = rd_in ? map_q[map_rd_row_i][map_rd_col_i] : '0;
  end

  // Map storage: host writes in IDLE only, barrier clear from EXEC.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int r = 0; r < int'(ROWS); r++) begin
        for (int c = 0; c < int'(COLS); c++) begin
          map_q[r][c] <= '0;
        end
      end
    end else if (state_q == StIdle && map_we_i && wr_in) begin
      map_q[map_row_i][map_col_i] <= map_wdata_i;
    end else if (state_q == StExec && clr) begin
      map_q[ahd.r][ahd.c] <= '0;
    end
  end

  // Command FSM with registered pose, status and sensors.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cmd_q   <= 3'd0;
      row_q   <= RW'(START_ROW);
      col_q   <= CW'(START_COL);
      ori_q   <= 2'(START_ORI);
      done_q  <= 1'b0;
      blk_q   <= 1'b0;
      head_q  <= 1'b0;
      left_q  <= 1'b0;
      under_q <= 1'b0;
      bar_q   <= 1'b0;
      mc_q    <= 16'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cmd_valid_i && cmd_ready_o) begin
            cmd_q   <= cmd_i;
            state_q <= StExec;
          end
        end
        StExec: begin
          // Sensors are taken from the post-EXEC pose so they line up with done.
          row_q   <= row_n;
          col_q   <= col_n;
          ori_q   <= ori_n;
          blk_q   <= blk_n;
          head_q  <= head_n;
          left_q  <= left_n;
          under_q <= under_n;
          bar_q   <= bar_n;
          done_q  <= 1'b1;
          if (fwd_ok && mc_q != 16'hFFFF) mc_q <= mc_q + 16'd1;
          state_q <= StSense;
        end
        StSense: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign done_o            = done_q;
  assign blocked_o         = blk_q;
  assign robo_row_o        = row_q;
  assign robo_col_o        = col_q;
  assign robo_orientacao_o = ori_q;
  assign head_out_o        = head_q;
  assign left_out_o        = left_q;
  assign under_out_o       = under_q;
  assign barrier_out_o     = bar_q;
  assign move_count_o      = mc_q;

endmodule

// File: tb/tb_robot_map_engine.sv
// Scoreboard bench for robot_map_engine (10x20 map, start pose 0,0,N).
module tb_robot_map_engine;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd = 3'd0;
  logic       done, blocked;
  logic [3:0] robo_row;
  logic [4:0] robo_col;
  logic [1:0] robo_ori;
  logic       head_out, left_out, under_out, barrier_out;
  logic       map_we = 1'b0;
  logic [3:0] map_row = '0;
  logic [4:0] map_col = '0;
  logic [2:0] map_wdata = '0;
  logic [3:0] map_rd_row = '0;
  logic [4:0] map_rd_col = '0;
  logic [2:0] map_rdata;
  logic [15:0] move_count;

  robot_map_engine dut (
    .clock_i           (clock),
    .reset_i           (reset),
    .cmd_valid_i       (cmd_valid),
    .cmd_ready_o       (cmd_ready),
    .cmd_i             (cmd),
    .done_o            (done),
    .blocked_o         (blocked),
    .robo_row_o        (robo_row),
    .robo_col_o        (robo_col),
    .robo_orientacao_o (robo_ori),
    .head_out_o        (head_out),
    .left_out_o        (left_out),
    .under_out_o       (under_out),
    .barrier_out_o     (barrier_out),
    .map_we_i          (map_we),
    .map_row_i         (map_row),
    .map_col_i         (map_col),
    .map_wdata_i       (map_wdata),
    .map_rd_row_i      (map_rd_row),
    .map_rd_col_i      (map_rd_col),
    .map_rdata_o       (map_rdata),
    .move_count_o      (move_count)
  );

  always #5 clock = ~clock;

  localparam logic [2:0] SENSE = 3'd0, FWD = 3'd1, TL = 3'd2, TR = 3'd3, CLR = 3'd4;

  typedef struct {
    int cyc;
    int row, col, ori, mc, blk, hd, lf, un, br;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clock) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_latency", cyc, e.cyc);
        chk("row", int'(robo_row), e.row);
        chk("col", int'(robo_col), e.col);
        chk("ori", int'(robo_ori), e.ori);
        chk("move_count", int'(move_count), e.mc);
        chk("blocked", int'(blocked), e.blk);
        chk("head_out", int'(head_out), e.hd);
        chk("left_out", int'(left_out), e.lf);
        chk("under_out", int'(under_out), e.un);
        chk("barrier_out", int'(barrier_out), e.br);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (cmd_ready !== 1'b1) chk("ready_timeout", int'(cmd_ready), 1);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (q.size() != 0) begin
      chk("done_timeout", q.size(), 0);
      q.delete();
    end
    @(negedge clock);
    wait_ready();
  endtask

  function automatic exp_t mk(int r, int c, int o, int mc, int b, int h, int l, int u, int br);
    exp_t e;
    e.cyc = 0; e.row = r; e.col = c; e.ori = o; e.mc = mc;
    e.blk = b; e.hd = h; e.lf = l; e.un = u; e.br = br;
    return e;
  endfunction

  task automatic issue(input logic [2:0] c, input exp_t e);
    @(negedge clock);
    wait_ready();
    cmd       = c;
    cmd_valid = 1'b1;
    e.cyc     = cyc + 2;
    q.push_back(e);
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    drain();
  endtask

  task automatic write_cell(input int r, input int c, input int d);
    @(negedge clock);
    wait_ready();
    map_we = 1'b1; map_row = 4'(r); map_col = 5'(c); map_wdata = 3'(d);
    @(posedge clock);
    #1 map_we = 1'b0;
  endtask

  task automatic read_chk(input string nm, input int r, input int c, input int exp);
    @(negedge clock);
    map_rd_row = 4'(r); map_rd_col = 5'(c);
    #1 chk(nm, int'(map_rdata), exp);
  endtask

  initial begin
    exp_t e;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_pose", {robo_row, robo_col, robo_ori}, 0);
    chk("rst_sensors", {head_out, left_out, under_out, barrier_out}, 0);
    chk("rst_done_blk", {done, blocked}, 0);
    chk("rst_mc", int'(move_count), 0);

    issue(SENSE, mk(0, 0, 0, 0, 0, 1, 1, 0, 0));
    issue(TR,    mk(0, 0, 1, 0, 0, 0, 1, 0, 0));
    issue(FWD,   mk(0, 1, 1, 1, 0, 0, 1, 0, 0));
    issue(FWD,   mk(0, 2, 1, 2, 0, 0, 1, 0, 0));
    issue(FWD,   mk(0, 3, 1, 3, 0, 0, 1, 0, 0));

    write_cell(0, 4, 2);
    read_chk("rd_barrier", 0, 4, 2);
    issue(FWD,   mk(0, 3, 1, 3, 1, 0, 1, 0, 1));
    @(negedge clock);
    chk("blocked_hold", int'(blocked), 1);
    issue(CLR,   mk(0, 3, 1, 3, 0, 0, 1, 0, 0));
    read_chk("rd_cleared", 0, 4, 0);
    issue(FWD,   mk(0, 4, 1, 4, 0, 0, 1, 0, 0));

    // Reset during EXEC of a FORWARD: no done, pose and count back to start.
    @(negedge clock);
    wait_ready();
    cmd = FWD; cmd_valid = 1'b1;
    @(posedge clock);
    #1 cmd_valid = 1'b0; reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (4) @(negedge clock);
    chk("abort_pose", {robo_row, robo_col, robo_ori}, 0);
    chk("abort_mc", int'(move_count), 0);
    chk("abort_left", int'(left_out), 0);

    // Write and command in the same IDLE cycle: write first, accept next cycle.
    @(negedge clock);
    wait_ready();
    map_we = 1'b1; map_row = 4'd1; map_col = 5'd0; map_wdata = 3'd3;
    cmd = TR; cmd_valid = 1'b1;
    #1 chk("ready_low_with_we", int'(cmd_ready), 0);
    @(posedge clock);
    #1 map_we = 1'b0;
    @(negedge clock);
    chk("ready_after_we", int'(cmd_ready), 1);
    e = mk(0, 0, 1, 0, 0, 0, 1, 0, 0);
    e.cyc = cyc + 2;
    q.push_back(e);
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    drain();
    read_chk("rd_garbage", 1, 0, 3);

    issue(TR,    mk(0, 0, 2, 0, 0, 0, 0, 0, 0));
    issue(FWD,   mk(1, 0, 2, 1, 0, 0, 0, 1, 0));

    // Map write during EXEC must be ignored.
    @(negedge clock);
    wait_ready();
    cmd = SENSE; cmd_valid = 1'b1;
    e = mk(1, 0, 2, 1, 0, 0, 0, 1, 0);
    e.cyc = cyc + 2;
    q.push_back(e);
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    map_we = 1'b1; map_row = 4'd5; map_col = 5'd5; map_wdata = 3'd1;
    @(posedge clock);
    #1 map_we = 1'b0;
    drain();
    read_chk("rd_exec_write_ignored", 5, 5, 0);

    issue(TL,    mk(1, 0, 1, 1, 0, 0, 0, 1, 0));
    issue(TL,    mk(1, 0, 0, 1, 0, 0, 1, 1, 0));
    issue(TL,    mk(1, 0, 3, 1, 0, 1, 0, 1, 0));
    issue(FWD,   mk(1, 0, 3, 1, 1, 1, 0, 1, 0));
    issue(TR,    mk(1, 0, 0, 1, 0, 0, 1, 1, 0));

    write_cell(0, 0, 1);
    write_cell(10, 0, 1);
    read_chk("rd_wall", 0, 0, 1);
    read_chk("rd_out_of_range", 10, 0, 0);
    issue(SENSE, mk(1, 0, 0, 1, 0, 1, 1, 1, 0));
    issue(FWD,   mk(1, 0, 0, 1, 1, 1, 1, 1, 0));
    issue(7,     mk(1, 0, 0, 1, 0, 1, 1, 1, 0));

    repeat (3) @(negedge clock);
    chk("scoreboard_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
